// File: rtl/gs_pkg.sv
// Shared definitions for the gs_gate datapath blocks.
//   GS_OP_*     : 3-bit operation select codes for the bitwise gate unit
//   gs_state_t  : occupancy state of the two-entry output/skid buffer
package gs_pkg;

    localparam logic [2:0] GS_OP_AND   = 3'd0;
    localparam logic [2:0] GS_OP_OR    = 3'd1;
    localparam logic [2:0] GS_OP_NAND  = 3'd2;
    localparam logic [2:0] GS_OP_NOR   = 3'd3;
    localparam logic [2:0] GS_OP_XOR   = 3'd4;
    localparam logic [2:0] GS_OP_XNOR  = 3'd5;
    localparam logic [2:0] GS_OP_NOTA  = 3'd6;
    localparam logic [2:0] GS_OP_PASSA = 3'd7;

    typedef enum logic [1:0] {
        GS_ST_EMPTY = 2'd0,
        GS_ST_ONE   = 2'd1,
        GS_ST_TWO   = 2'd2
    } gs_state_t;

endpackage

// File: rtl/gs_gate_bitwise.sv
// Combinational WIDTH-bit bitwise gate with runtime operation select.
// Each result bit depends only on the same bit index of a and b.
//   a, b : operands
//   op   : operation select (GS_OP_* codes)
//   y    : bitwise result
module gs_gate_bitwise
    import gs_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            GS_OP_AND:   y = a & b;
            GS_OP_OR:    y = a | b;
            GS_OP_NAND:  y = ~(a & b);
            GS_OP_NOR:   y = ~(a | b);
            GS_OP_XOR:   y = a ^ b;
            GS_OP_XNOR:  y = ~(a ^ b);
            GS_OP_NOTA:  y = ~a;
            GS_OP_PASSA: y = a;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/gs_gate_pipe.sv
// Registered bitwise gate unit with valid/ready handshake on both sides.
// The result (plus its AND/OR reductions) is computed at accept time and
// held in a two-entry buffer (output register + skid register), so the
// unit sustains one result per cycle while in_ready stays a pure register.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready registered)
//   a, b, op            : operands and operation select
//   out_valid/out_ready : output handshake
//   y, y_all, y_any     : presented result and its &/| reductions
//   n_done              : saturating count of completed output handshakes
module gs_gate_pipe
    import gs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic [CNT_W-1:0] n_done
);

    // Result word layout: {any, all, y}
    localparam int RES_W = WIDTH + 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    gs_state_t        state_q, state_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] n_done_q;
    logic [WIDTH-1:0] gate_y;
    logic [RES_W-1:0] new_res_p0;
    logic [RES_W-1:0] out_res_p1;
    logic [RES_W-1:0] skid_res_p1;
    logic             accept, deliver;
    logic             load_out_new, load_out_skid, load_skid;

    // ---- Stage p0: combinational gate on the accepted operands ----
    gs_gate_bitwise #(.WIDTH(WIDTH)) u_bitwise (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (gate_y)
    );

    assign new_res_p0 = {|gate_y, &gate_y, gate_y};

    assign out_valid = (state_q != GS_ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            GS_ST_EMPTY: begin
                if (accept) begin
                    state_d      = GS_ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            GS_ST_ONE: begin
                if (accept && deliver) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_d   = GS_ST_TWO;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_d = GS_ST_EMPTY;
                end
            end
            GS_ST_TWO: begin
                // in_ready is low here, so no accept can coincide
                if (deliver) begin
                    state_d       = GS_ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = GS_ST_EMPTY;
        endcase
    end

    // ---- Stage p1: state, output register, counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= GS_ST_EMPTY;
            in_ready_q <= 1'b1;
            n_done_q   <= '0;
            out_res_p1 <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != GS_ST_TWO);
            if (deliver) begin
                n_done_q <= sat_inc(n_done_q);
            end
            if (load_out_new) begin
                out_res_p1 <= new_res_p0;
            end else if (load_out_skid) begin
                out_res_p1 <= skid_res_p1;
            end
        end
    end

    // Skid contents are only ever read in TWO, which is always preceded by a load
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_res_p1 <= new_res_p0;
        end
    end

    assign in_ready = in_ready_q;
    assign n_done   = n_done_q;
    assign y        = out_res_p1[WIDTH-1:0];
    assign y_all    = out_res_p1[WIDTH];
    assign y_any    = out_res_p1[WIDTH+1];

endmodule

// File: tb/tb_gs_gate_pipe.sv
module tb_gs_gate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    // main instance, WIDTH=8 CNT_W=16
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, y;
    logic [2:0] op;
    logic       y_all, y_any;
    logic [15:0] n_done;
    // saturation instance, WIDTH=8 CNT_W=2
    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0] a2, b2, y2;
    logic [2:0] op2;
    logic       y_all2, y_any2;
    logic [1:0] n_done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gs_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_all(y_all), .y_any(y_any), .n_done(n_done)
    );

    gs_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .y_all(y_all2), .y_any(y_any2), .n_done(n_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [2:0] mop);
        logic [7:0] r;
        case (mop)
            3'd0: r = ma & mb;
            3'd1: r = ma | mb;
            3'd2: r = ~(ma & mb);
            3'd3: r = ~(ma | mb);
            3'd4: r = ma ^ mb;
            3'd5: r = ~(ma ^ mb);
            3'd6: r = ~ma;
            default: r = ma;
        endcase
        return {|r, &r, r};
    endfunction

    logic [7:0] exp_t2 [8];
    logic [9:0] q [$];
    logic [9:0] exp_res;

    initial begin
        exp_t2 = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        rst = 1'b1;
        in_valid = 0; out_ready = 1; a = 0; b = 0; op = 0;
        in_valid2 = 0; out_ready2 = 1; a2 = 0; b2 = 0; op2 = 0;

        // 1. reset
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_y",         32'(y),         32'd0);
        chk("rst_y_all",     32'(y_all),     32'd0);
        chk("rst_y_any",     32'(y_any),     32'd0);
        chk("rst_n_done",    32'(n_done),    32'd0);

        // 2. all eight ops, one per cycle
        a = 8'hF0; b = 8'hCC; out_ready = 1; in_valid = 1; op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t2_valid_op%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t2_y_op%0d", i),     32'(y),         32'(exp_t2[i]));
            chk($sformatf("t2_all_op%0d", i),   32'(y_all),     32'd0);
            chk($sformatf("t2_any_op%0d", i),   32'(y_any),     32'd1);
            chk($sformatf("t2_ready_op%0d", i), 32'(in_ready),  32'd1);
            op = 3'(i + 1);
        end
        in_valid = 0;
        step();
        chk("t2_empty",  32'(out_valid), 32'd0);
        chk("t2_n_done", 32'(n_done),    32'd8);

        // 3. reduction corners
        a = 8'hFF; b = 8'hFF; op = 3'd0; in_valid = 1;
        step();
        chk("t3_ff_y",   32'(y),     32'hFF);
        chk("t3_ff_all", 32'(y_all), 32'd1);
        chk("t3_ff_any", 32'(y_any), 32'd1);
        a = 8'h00; b = 8'h00; op = 3'd1;
        step();
        chk("t3_00_valid", 32'(out_valid), 32'd1);
        chk("t3_00_y",     32'(y),     32'h00);
        chk("t3_00_all",   32'(y_all), 32'd0);
        chk("t3_00_any",   32'(y_any), 32'd0);
        in_valid = 0;
        step();
        chk("t3_n_done", 32'(n_done), 32'd10);

        // 4. backpressure fills the skid
        out_ready = 0; a = 8'hF0; b = 8'hCC; op = 3'd0; in_valid = 1;
        step();
        chk("t4_first_y",     32'(y),        32'hC0);
        chk("t4_first_ready", 32'(in_ready), 32'd1);
        op = 3'd1;
        step();
        chk("t4_two_ready", 32'(in_ready),  32'd0);
        chk("t4_two_valid", 32'(out_valid), 32'd1);
        chk("t4_two_y",     32'(y),         32'hC0);
        op = 3'd2;
        step();
        chk("t4_hold_ready", 32'(in_ready), 32'd0);
        chk("t4_hold_y",     32'(y),        32'hC0);
        chk("t4_hold_all",   32'(y_all),    32'd0);
        chk("t4_hold_any",   32'(y_any),    32'd1);
        out_ready = 1;
        step();
        chk("t4_second_y",     32'(y),        32'hFC);
        chk("t4_second_ready", 32'(in_ready), 32'd1);
        step();
        chk("t4_third_y", 32'(y), 32'h3F);
        in_valid = 0;
        step();
        chk("t4_empty",  32'(out_valid), 32'd0);
        chk("t4_n_done", 32'(n_done),    32'd13);

        // 5. random handshakes against a reference queue
        begin
            int sent = 0;
            int got = 0;
            int cycles = 0;
            bit pending = 0;
            while (got < 1000 && cycles < 20000) begin
                if (!pending) begin
                    if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                        a = 8'($urandom);
                        b = 8'($urandom);
                        op = 3'($urandom);
                        in_valid = 1;
                        pending = 1;
                    end else begin
                        in_valid = 0;
                    end
                end
                out_ready = ($urandom_range(0, 1) == 1);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("t5_spurious", 32'd1, 32'd0);
                    end else begin
                        exp_res = q.pop_front();
                        chk("t5_result", 32'({y_any, y_all, y}), 32'(exp_res));
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(a, b, op));
                    sent++;
                    pending = 0;
                end
                step();
                cycles++;
            end
            in_valid = 0;
            out_ready = 1;
            chk("t5_delivered", 32'(got),      32'd1000);
            chk("t5_q_empty",   32'(q.size()), 32'd0);
            chk("t5_n_done",    32'(n_done),   32'd1013);
        end
        step();
        chk("t5_idle", 32'(out_valid), 32'd0);

        // 6. counter saturation on the CNT_W=2 instance, then reset from TWO
        a2 = 8'h5A; b2 = 8'h0F; op2 = 3'd4; in_valid2 = 1; out_ready2 = 1;
        step();
        chk("t6_n0", 32'(n_done2), 32'd0);
        chk("t6_y",  32'(y2),      32'h55);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t6_n_deliv%0d", i + 1), 32'(n_done2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        out_ready2 = 0;
        step();
        chk("t6_two_ready", 32'(in_ready2),  32'd0);
        chk("t6_two_valid", 32'(out_valid2), 32'd1);
        rst = 1;
        step();
        rst = 0;
        in_valid2 = 0;
        chk("t6_rst_valid", 32'(out_valid2), 32'd0);
        chk("t6_rst_ready", 32'(in_ready2),  32'd1);
        chk("t6_rst_n",     32'(n_done2),    32'd0);
        chk("t6_rst_y",     32'(y2),         32'd0);
        chk("t6_rst_main_n", 32'(n_done),    32'd0);
        out_ready2 = 1;
        step();
        chk("t6_post_valid", 32'(out_valid2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
